// File: rtl/reset_seq_pkg.sv
// Shared types for the reset release sequencer: FSM state encoding and
// stretch-counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  localparam int unsigned STRETCH_CYCLES_DEFAULT = 8;

  // Counter must hold the load value STRETCH_CYCLES itself.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(STRETCH_CYCLES_DEFAULT);

endpackage

// File: rtl/reset_sync_chain.sv
// Deassertion synchronizer: async-cleared shift chain fed with a constant 1,
// so 'released' rises SYNC_STAGES edges after rst falls.
module reset_sync_chain #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  output logic released
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign released = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Core reset generator: async assertion, synchronized and stretched release,
// plus a software-requested reset pulse with a completion acknowledge.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned STRETCH_CYCLES = STRETCH_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req,
  output logic       rst_out,
  output logic       rst_n_out,
  output logic       sw_ack,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = cnt_width(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             released;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sw_pending_q;
  logic             rst_out_q;
  logic             sw_ack_q;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .released(released)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      sw_pending_q <= 1'b0;
      rst_out_q    <= 1'b1;
      sw_ack_q     <= 1'b0;
    end else begin
      sw_ack_q <= 1'b0;
      case (state_q)
        HOLD: begin
          rst_out_q <= 1'b1;
          if (released) begin
            state_q <= STRETCH;
            cnt_q   <= CNT_LOAD;
          end
        end
        STRETCH: begin
          rst_out_q <= 1'b1;
          // Exit on count<=1 so a corrupted zero count cannot trap the FSM.
          if (cnt_q <= CNT_ONE) begin
            state_q      <= RUN;
            rst_out_q    <= 1'b0;
            cnt_q        <= '0;
            sw_ack_q     <= sw_pending_q;
            sw_pending_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        RUN: begin
          rst_out_q <= 1'b0;
          if (sw_req) begin
            state_q      <= STRETCH;
            rst_out_q    <= 1'b1;
            cnt_q        <= CNT_LOAD;
            sw_pending_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= HOLD;
          rst_out_q    <= 1'b1;
          cnt_q        <= '0;
          sw_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_n_out = ~rst_out_q;
  assign sw_ack    = sw_ack_q;
  assign state     = state_q;

endmodule
